// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit with HI/LO registers.
package muldiv_pkg;

    localparam int unsigned WIDTH_DEF = 32;
    localparam int unsigned CNT_W_DEF = 6;

    // op[0] selects divide, op[1] selects signed
    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_DIVU  = 2'b01;
    localparam logic [1:0] OP_MULT  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

endpackage

// File: rtl/muldiv_iter.sv
// Datapath for one radix-2 iteration: shift-add multiply or restoring shift-subtract divide.
module muldiv_iter
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic             op_is_div,
    input  logic [WIDTH-1:0] load_lo,
    input  logic [WIDTH-1:0] load_b,
    output logic [WIDTH-1:0] acc_hi,
    output logic [WIDTH-1:0] acc_lo
);

    logic [WIDTH-1:0] b_r;
    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   shl;
    logic [WIDTH:0]   sub_diff;

    // Remainder stays below the divisor, so bit WIDTH of the difference is a clean borrow flag
    always_comb begin
        add_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, b_r} : (WIDTH+1)'(0));
        shl      = {acc_hi, acc_lo[WIDTH-1]};
        sub_diff = shl - {1'b0, b_r};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_hi <= '0;
            acc_lo <= '0;
            b_r    <= '0;
        end else if (load) begin
            acc_hi <= '0;
            acc_lo <= load_lo;
            b_r    <= load_b;
        end else if (step) begin
            if (op_is_div) begin
                if (!sub_diff[WIDTH]) begin
                    acc_hi <= sub_diff[WIDTH-1:0];
                    acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
                end else begin
                    acc_hi <= shl[WIDTH-1:0];
                    acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
                end
            end else begin
                acc_hi <= add_sum[WIDTH:1];
                acc_lo <= {add_sum[0], acc_lo[WIDTH-1:1]};
            end
        end
    end

endmodule

// File: rtl/muldiv_hilo.sv
// Multi-cycle multiply/divide unit with architectural HI/LO, busy/done handshake and MTHI/MTLO.
module muldiv_hilo
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               is_div;
    logic               neg_q;
    logic               neg_r;
    logic               load;
    logic               step;
    logic [WIDTH-1:0]   abs1;
    logic [WIDTH-1:0]   abs2;
    logic [WIDTH-1:0]   acc_hi;
    logic [WIDTH-1:0]   acc_lo;
    logic [WIDTH-1:0]   q_fix;
    logic [WIDTH-1:0]   r_fix;
    logic [2*WIDTH-1:0] prod_fix;

    // Magnitudes for the unsigned core, and sign fix-up of the finished result
    always_comb begin
        load     = (state == IDLE) && start;
        step     = (state == RUN);
        abs1     = (op[1] && in1[WIDTH-1]) ? -in1 : in1;
        abs2     = (op[1] && in2[WIDTH-1]) ? -in2 : in2;
        prod_fix = neg_q ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
        q_fix    = neg_q ? -acc_lo : acc_lo;
        r_fix    = neg_r ? -acc_hi : acc_hi;
    end

    muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .step      (step),
        .op_is_div (is_div),
        .load_lo   (op[0] ? abs1 : abs2),
        .load_b    (op[0] ? abs2 : abs1),
        .acc_hi    (acc_hi),
        .acc_lo    (acc_lo)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        is_div <= op[0];
                        neg_q  <= op[1] & (in1[WIDTH-1] ^ in2[WIDTH-1]);
                        neg_r  <= op[1] & in1[WIDTH-1];
                        cnt    <= '0;
                        busy   <= 1'b1;
                        if (op[0] && (in2 == '0)) begin
                            div_zero <= 1'b1;
                            state    <= FINISH;
                        end else begin
                            div_zero <= 1'b0;
                            state    <= RUN;
                        end
                    end else begin
                        if (mthi) hi <= wdata;
                        if (mtlo) lo <= wdata;
                    end
                end
                RUN: begin
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH - 1)) state <= FINISH;
                end
                FINISH: begin
                    if (div_zero) begin
                        hi <= '0;
                        lo <= '0;
                    end else if (is_div) begin
                        hi <= r_fix;
                        lo <= q_fix;
                    end else begin
                        {hi, lo} <= prod_fix;
                    end
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
